// File: rtl/tone_scheduler.sv
// tone_scheduler: beat-synchronous arbiter that shares one tone generator
// between the song player, the replay engine and the live keyboard, converts
// the selected note to the tone-counter preload, and records/replays keyboard
// note changes through a small buffer.
module tone_scheduler #(
    parameter int DEPTH = 51,
    parameter int PTR_W = 6
) (
    input  logic             sys_CLK,
    input  logic             rst,
    input  logic             beat_tick,
    input  logic             song_req,
    input  logic [4:0]       song_note,
    input  logic             key_req,
    input  logic [4:0]       key_note,
    input  logic             replay_req,
    input  logic             rec_clear,
    output logic [4:0]       note,
    output logic [13:0]      origin,
    output logic [1:0]       owner,
    output logic [PTR_W-1:0] rec_count,
    output logic             replay_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SONG   = 2'd1,
        REPLAY = 2'd2,
        KEY    = 2'd3
    } state_t;

    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    state_t           owner_q, owner_d, next_owner;
    logic [4:0]       note_q, note_d;
    logic [13:0]      origin_q, origin_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rec_count_q, rec_count_d;
    logic [4:0]       last_q, last_d;
    logic             done_q, done_d;

    // Effective values after a coincident clear has been applied
    logic [PTR_W-1:0] cnt_eff;
    logic [4:0]       last_eff;
    logic [PTR_W-1:0] rd_base;
    logic [PTR_W-1:0] rd_inc;

    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;

    logic [4:0]       rec_mem [0:DEPTH-1];

    // Note index to 14-bit tone counter preload; out-of-range notes are silent
    function automatic logic [13:0] note_to_origin(input logic [4:0] n);
        logic [13:0] o;
        case (n)
            5'd1:    o = 14'd4916;
            5'd2:    o = 14'd6168;
            5'd3:    o = 14'd7281;
            5'd4:    o = 14'd7791;
            5'd5:    o = 14'd8730;
            5'd6:    o = 14'd9565;
            5'd7:    o = 14'd10310;
            5'd8:    o = 14'd10647;
            5'd9:    o = 14'd11272;
            5'd10:   o = 14'd11831;
            5'd11:   o = 14'd12087;
            5'd12:   o = 14'd12556;
            5'd13:   o = 14'd12974;
            5'd14:   o = 14'd13346;
            5'd15:   o = 14'd13516;
            5'd16:   o = 14'd13829;
            5'd17:   o = 14'd14108;
            5'd18:   o = 14'd14236;
            5'd19:   o = 14'd14470;
            5'd20:   o = 14'd14678;
            5'd21:   o = 14'd14864;
            default: o = 14'd0;
        endcase
        return o;
    endfunction

    // Fixed-priority arbitration: song > replay > key > idle
    always_comb begin
        if (song_req)        next_owner = SONG;
        else if (replay_req) next_owner = REPLAY;
        else if (key_req)    next_owner = KEY;
        else                 next_owner = IDLE;
    end

    // Next-state, note select, replay pointer and record-write decisions
    always_comb begin
        cnt_eff  = rec_clear ? '0 : rec_count_q;
        last_eff = rec_clear ? 5'd0 : last_q;
        // A fresh replay (or one hit by a clear) always starts from entry 0
        rd_base  = (rec_clear || owner_q != REPLAY) ? '0 : rd_ptr_q;
        rd_inc   = rd_base + 1'b1;

        owner_d     = owner_q;
        note_d      = note_q;
        rd_ptr_d    = rec_clear ? '0 : rd_ptr_q;
        rec_count_d = cnt_eff;
        last_d      = last_eff;
        done_d      = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = cnt_eff;

        if (beat_tick) begin
            owner_d = next_owner;
            case (next_owner)
                SONG: note_d = song_note;
                KEY: begin
                    note_d = key_note;
                    // Record only note changes; saturate when full
                    if ((cnt_eff == '0 || key_note != last_eff) && cnt_eff < DEPTH_P) begin
                        wr_en       = 1'b1;
                        rec_count_d = cnt_eff + 1'b1;
                        last_d      = key_note;
                    end
                end
                REPLAY: begin
                    if (cnt_eff == '0) begin
                        note_d   = 5'd0;
                        rd_ptr_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        note_d = rec_mem[rd_base];
                        if (rd_inc == cnt_eff) begin
                            rd_ptr_d = '0;
                            done_d   = 1'b1;
                        end else begin
                            rd_ptr_d = rd_inc;
                        end
                    end
                end
                default: note_d = 5'd0;
            endcase
        end

        origin_d = beat_tick ? note_to_origin(note_d) : origin_q;
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge sys_CLK or posedge rst) begin
        if (rst) begin
            owner_q     <= IDLE;
            note_q      <= 5'd0;
            origin_q    <= 14'd0;
            rd_ptr_q    <= '0;
            rec_count_q <= '0;
            last_q      <= 5'd0;
            done_q      <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            note_q      <= note_d;
            origin_q    <= origin_d;
            rd_ptr_q    <= rd_ptr_d;
            rec_count_q <= rec_count_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    // Record buffer storage; contents survive reset
    always_ff @(posedge sys_CLK) begin
        if (wr_en) rec_mem[wr_addr] <= key_note;
    end

    assign note        = note_q;
    assign origin      = origin_q;
    assign owner       = owner_q;
    assign rec_count   = rec_count_q;
    assign replay_done = done_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed testbench for tone_scheduler: table of single-tick vectors plus
// hand-written sequences for hold, saturation, clear, back-to-back ticks and
// asynchronous reset.
module tb_tone_scheduler;

    logic       sys_CLK = 1'b0;
    logic       rst = 1'b1;
    logic       beat_tick = 1'b0;
    logic       song_req = 1'b0;
    logic [4:0] song_note = 5'd0;
    logic       key_req = 1'b0;
    logic [4:0] key_note = 5'd0;
    logic       replay_req = 1'b0;
    logic       rec_clear = 1'b0;
    logic [4:0] note;
    logic [13:0] origin;
    logic [1:0] owner;
    logic [5:0] rec_count;
    logic       replay_done;

    int n_checks = 0;
    int n_fails  = 0;

    tone_scheduler #(.DEPTH(51), .PTR_W(6)) dut (
        .sys_CLK    (sys_CLK),
        .rst        (rst),
        .beat_tick  (beat_tick),
        .song_req   (song_req),
        .song_note  (song_note),
        .key_req    (key_req),
        .key_note   (key_note),
        .replay_req (replay_req),
        .rec_clear  (rec_clear),
        .note       (note),
        .origin     (origin),
        .owner      (owner),
        .rec_count  (rec_count),
        .replay_done(replay_done)
    );

    always #5 sys_CLK = ~sys_CLK;

    typedef struct {
        logic       sreq;
        logic [4:0] snote;
        logic       kreq;
        logic [4:0] knote;
        logic       rreq;
        int         e_owner;
        int         e_note;
        int         e_origin;
        int         e_count;
        int         e_done;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int eo, input int en, input int eg,
                           input int ec, input int ed);
        chk({tag, ".owner"}, int'(owner), eo);
        chk({tag, ".note"}, int'(note), en);
        chk({tag, ".origin"}, int'(origin), eg);
        chk({tag, ".rec_count"}, int'(rec_count), ec);
        chk({tag, ".replay_done"}, int'(replay_done), ed);
        $display("%s: owner=%0d note=%0d origin=%0d rec_count=%0d done=%0d",
                 tag, owner, note, origin, rec_count, replay_done);
    endtask

    // One beat tick with the currently driven inputs; returns 1 ns after the edge
    task automatic do_tick();
        @(negedge sys_CLK);
        beat_tick = 1'b1;
        @(posedge sys_CLK);
        #1;
        beat_tick = 1'b0;
        rec_clear = 1'b0;
    endtask

    task automatic set_in(input logic sr, input logic [4:0] sn, input logic kr,
                          input logic [4:0] kn, input logic rr);
        song_req = sr; song_note = sn; key_req = kr; key_note = kn; replay_req = rr;
    endtask

    initial begin
        //               sreq snote kreq knote rreq  own note origin  cnt done
        tbl[0]  = '{1'b1, 5'd8,  1'b0, 5'd0,  1'b0, 1, 8,  10647, 0, 0};
        tbl[1]  = '{1'b1, 5'd8,  1'b1, 5'd8,  1'b0, 1, 8,  10647, 0, 0};
        tbl[2]  = '{1'b0, 5'd8,  1'b1, 5'd8,  1'b0, 3, 8,  10647, 1, 0};
        tbl[3]  = '{1'b0, 5'd0,  1'b1, 5'd8,  1'b0, 3, 8,  10647, 1, 0};
        tbl[4]  = '{1'b0, 5'd0,  1'b1, 5'd9,  1'b0, 3, 9,  11272, 2, 0};
        tbl[5]  = '{1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 3, 0,  0,     3, 0};
        tbl[6]  = '{1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 3, 0,  0,     3, 0};
        tbl[7]  = '{1'b0, 5'd0,  1'b1, 5'd10, 1'b0, 3, 10, 11831, 4, 0};
        tbl[8]  = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 2, 8,  10647, 4, 0};
        tbl[9]  = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 2, 9,  11272, 4, 0};
        tbl[10] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 2, 0,  0,     4, 0};
        tbl[11] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 2, 10, 11831, 4, 1};
        tbl[12] = '{1'b0, 5'd0,  1'b1, 5'd3,  1'b1, 2, 8,  10647, 4, 0};
        tbl[13] = '{1'b1, 5'd21, 1'b0, 5'd0,  1'b1, 1, 21, 14864, 4, 0};
        tbl[14] = '{1'b0, 5'd21, 1'b0, 5'd0,  1'b0, 0, 0,  0,     4, 0};
        tbl[15] = '{1'b0, 5'd0,  1'b1, 5'd16, 1'b0, 3, 16, 13829, 5, 0};

        // Reset with a pending song request: everything stays zero
        set_in(1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
        repeat (3) @(posedge sys_CLK);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge sys_CLK);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            set_in(tbl[i].sreq, tbl[i].snote, tbl[i].kreq, tbl[i].knote, tbl[i].rreq);
            if (i == 2) begin
                // song_req dropped between ticks: ownership must not change yet
                repeat (3) @(posedge sys_CLK);
                #1;
                chk("hold.owner", int'(owner), 1);
                chk("hold.note", int'(note), 8);
            end
            do_tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_owner, tbl[i].e_note,
                    tbl[i].e_origin, tbl[i].e_count, tbl[i].e_done);
        end

        // Clear off-tick, then fill past capacity with alternating notes
        @(negedge sys_CLK);
        rec_clear = 1'b1;
        @(posedge sys_CLK);
        #1;
        rec_clear = 1'b0;
        chk("clear.rec_count", int'(rec_count), 0);
        for (int i = 0; i < 60; i++) begin
            set_in(1'b0, 5'd0, 1'b1, (i % 2 == 0) ? 5'd1 : 5'd2, 1'b0);
            do_tick();
            if (i == 49) chk("sat50.rec_count", int'(rec_count), 50);
        end
        chk_all("saturated", 3, 2, 6168, 51, 0);

        // Clear coincident with a KEY tick: write lands at entry 0
        set_in(1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
        rec_clear = 1'b1;
        do_tick();
        chk_all("clear+key5", 3, 5, 8730, 1, 0);
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        do_tick();
        chk_all("replay1a", 2, 5, 8730, 1, 1);
        do_tick();
        chk_all("replay1b", 2, 5, 8730, 1, 1);

        // Clear coincident with a REPLAY tick outputs silence
        rec_clear = 1'b1;
        do_tick();
        chk_all("clear+replay", 2, 0, 0, 0, 1);
        do_tick();
        chk_all("replay_empty", 2, 0, 0, 0, 1);

        // Origin boundaries through the keyboard
        set_in(1'b0, 5'd0, 1'b1, 5'd18, 1'b0);
        do_tick();
        chk_all("key18", 3, 18, 14236, 1, 0);
        set_in(1'b0, 5'd0, 1'b1, 5'd25, 1'b0);
        do_tick();
        chk_all("key25", 3, 25, 0, 2, 0);

        // Back-to-back ticks in replay: buffer holds 18, 25
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        @(negedge sys_CLK);
        beat_tick = 1'b1;
        @(posedge sys_CLK);
        #1;
        chk_all("b2b0", 2, 18, 14236, 2, 0);
        @(posedge sys_CLK);
        #1;
        chk_all("b2b1", 2, 25, 0, 2, 1);
        @(posedge sys_CLK);
        #1;
        beat_tick = 1'b0;
        chk_all("b2b2", 2, 18, 14236, 2, 0);

        // Asynchronous reset mid-replay: outputs clear without a clock edge
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge sys_CLK);
        rst = 1'b0;
        do_tick();
        chk_all("post_rst_replay", 2, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
